// File: rtl/tsc_multi.sv
// Per-channel key-parity sampler driving rotate/LFSR shift registers, plus a sticky activity-arming FSM.
// All outputs registered, one-edge latency from inputs; no handshake, never stalls its AES neighbours.
module tsc_multi #(
  parameter int               DATA_W    = 128,
  parameter int               CH        = 8,
  parameter int               TAP_W     = 8,
  parameter int               SHR_W     = 8,
  parameter logic [SHR_W-1:0] INIT      = 8'hAA,
  parameter logic [SHR_W-1:0] POLY      = 8'hB8,
  parameter int               ARM_COUNT = 16,
  parameter int               CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [1:0]           mode,
  input  logic [DATA_W-1:0]    state,
  input  logic [CH*DATA_W-1:0] rk_flat,
  input  logic [CH-1:0]        rk_valid,
  output logic [CH-1:0]        enable,
  output logic [CH*SHR_W-1:0]  shr_flat,
  output logic [CNT_W-1:0]     act_cnt,
  output logic                 armed
);

  typedef enum logic [1:0] {IDLE, RUN, ARMED} fsm_t;

  localparam logic [CNT_W-1:0] ARM_C = CNT_W'(ARM_COUNT);

  fsm_t                        fsm_q, fsm_nx;
  logic [CH-1:0][SHR_W-1:0]    shr_q, shr_nx;
  logic [CH-1:0]               en_nx;
  logic [CNT_W-1:0]            cnt_nx;
  logic                        armed_nx;
  logic                        upd;
  logic                        unused_taps;

  // Only the low TAP_W bits feed parity; the rest of the tapped buses are ignored.
  assign unused_taps = ^{state, rk_flat};
  assign shr_flat    = shr_q;

  always_comb begin
    en_nx = enable;
    for (int i = 0; i < CH; i++) begin
      if (rk_valid[i]) begin
        en_nx[i] = ^(state[TAP_W-1:0] & rk_flat[i*DATA_W +: TAP_W]);
      end
    end
  end

  // Steps use the registered enable, so a same-edge key strobe only affects the next edge.
  always_comb begin
    shr_nx = shr_q;
    upd    = (fsm_q == RUN) || (fsm_q == ARMED);
    for (int i = 0; i < CH; i++) begin
      if (upd) begin
        case (mode)
          2'b01: if (enable[i]) shr_nx[i] = {shr_q[i][0], shr_q[i][SHR_W-1:1]};
          2'b10: shr_nx[i] = {shr_q[i][0], shr_q[i][SHR_W-1:1]};
          2'b11: begin
            if (enable[i]) begin
              if (shr_q[i] == '0) shr_nx[i] = INIT;
              else shr_nx[i] = {1'b0, shr_q[i][SHR_W-1:1]} ^ (shr_q[i][0] ? POLY : '0);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    fsm_nx   = fsm_q;
    cnt_nx   = act_cnt;
    armed_nx = armed;
    case (fsm_q)
      IDLE: begin
        if (mode != 2'b00) fsm_nx = armed ? ARMED : RUN;
      end
      RUN: begin
        if (mode == 2'b00) begin
          fsm_nx = IDLE;
          cnt_nx = '0;
        end else if (|enable) begin
          cnt_nx = act_cnt + 1'b1;
          if (cnt_nx == ARM_C) begin
            fsm_nx   = ARMED;
            armed_nx = 1'b1;
          end
        end
      end
      ARMED: begin
        cnt_nx = ARM_C;
        if (mode == 2'b00) fsm_nx = IDLE;
      end
      default: fsm_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= IDLE;
      shr_q   <= {CH{INIT}};
      enable  <= '0;
      act_cnt <= '0;
      armed   <= 1'b0;
    end else if (clr) begin
      fsm_q   <= IDLE;
      shr_q   <= {CH{INIT}};
      enable  <= '0;
      act_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      fsm_q   <= fsm_nx;
      shr_q   <= shr_nx;
      enable  <= en_nx;
      act_cnt <= cnt_nx;
      armed   <= armed_nx;
    end
  end

endmodule

// File: tb/tb_tsc_multi.sv
// Directed bench for tsc_multi: main instance arms after 4 active cycles; two extra builds cover LFSR zero-lock and INIT=01.
module tb_tsc_multi;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [127:0]  state = '0;
  logic [1023:0] rk_flat = '0;
  logic [7:0]    rk_valid = '0;

  logic [7:0]  d_en,  z_en,  o_en;
  logic [63:0] d_shr, z_shr, o_shr;
  logic [7:0]  d_cnt, z_cnt, o_cnt;
  logic        d_arm, z_arm, o_arm;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tsc_multi #(.ARM_COUNT(4)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .state(state),
    .rk_flat(rk_flat), .rk_valid(rk_valid),
    .enable(d_en), .shr_flat(d_shr), .act_cnt(d_cnt), .armed(d_arm));

  tsc_multi #(.ARM_COUNT(4), .INIT(8'h00)) u_zero (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .state(state),
    .rk_flat(rk_flat), .rk_valid(rk_valid),
    .enable(z_en), .shr_flat(z_shr), .act_cnt(z_cnt), .armed(z_arm));

  tsc_multi #(.ARM_COUNT(4), .INIT(8'h01)) u_one (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .state(state),
    .rk_flat(rk_flat), .rk_valid(rk_valid),
    .enable(o_en), .shr_flat(o_shr), .act_cnt(o_cnt), .armed(o_arm));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_shr"}, d_shr, 64'hAAAA_AAAA_AAAA_AAAA);
    chk({tag, "_en"},  64'(d_en), 64'h0);
    chk({tag, "_cnt"}, 64'(d_cnt), 64'h0);
    chk({tag, "_arm"}, 64'(d_arm), 64'h0);
  endtask

  initial begin
    // Power-on reset
    #8;
    chk_reset("por");
    chk("por_zero_shr", z_shr, 64'h0);
    chk("por_one_shr",  o_shr, 64'h0101_0101_0101_0101);
    rst = 1'b1;

    // Gated rotate on ch0 with parity 1
    state[7:0] = 8'h01; rk_flat[7:0] = 8'h01; rk_valid = 8'h01;
    tick();
    chk("rot_en_load", 64'(d_en), 64'h01);
    rk_valid = 8'h00; mode = 2'b01;
    tick();
    chk("rot_idle_edge", d_shr, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("rot_idle_cnt", 64'(d_cnt), 64'h0);
    tick();
    chk("rot_step1", d_shr, 64'hAAAA_AAAA_AAAA_AA55);
    chk("rot_cnt1", 64'(d_cnt), 64'h1);
    tick();
    chk("rot_step2", d_shr, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("rot_cnt2", 64'(d_cnt), 64'h2);

    // Parity 0 strobe: this edge still steps on the old enable, then ch0 freezes
    state[7:0] = 8'h03; rk_flat[7:0] = 8'h03; rk_valid = 8'h01;
    tick();
    chk("par0_last_step", d_shr, 64'hAAAA_AAAA_AAAA_AA55);
    chk("par0_en", 64'(d_en), 64'h00);
    rk_valid = 8'h00;
    tick();
    chk("par0_frozen", d_shr, 64'hAAAA_AAAA_AAAA_AA55);
    chk("par0_cnt3", 64'(d_cnt), 64'h3);

    // Three active cycles then back to hold: counter drops, no arm
    mode = 2'b00;
    tick();
    chk("run_idle_cnt", 64'(d_cnt), 64'h0);
    chk("run_idle_arm", 64'(d_arm), 64'h0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_reset("clr1");

    // LFSR on ch0, arming after four active edges
    state[7:0] = 8'h01; rk_flat[7:0] = 8'h01; rk_valid = 8'h01; mode = 2'b11;
    tick();
    rk_valid = 8'h00;
    chk("lfsr_idle_edge", d_shr, 64'hAAAA_AAAA_AAAA_AAAA);
    tick();
    chk("lfsr_step1", d_shr, 64'hAAAA_AAAA_AAAA_AA55);
    chk("lfsr_zero_hold1", z_shr, 64'h0);
    chk("lfsr_one_step1", o_shr, 64'h0101_0101_0101_01B8);
    tick();
    chk("lfsr_step2", d_shr, 64'hAAAA_AAAA_AAAA_AA92);
    chk("lfsr_zero_hold2", z_shr, 64'h0);
    chk("lfsr_one_step2", o_shr, 64'h0101_0101_0101_015C);
    tick();
    chk("arm_cnt3", 64'(d_cnt), 64'h3);
    chk("arm_not_yet", 64'(d_arm), 64'h0);
    chk("lfsr_step3", d_shr, 64'hAAAA_AAAA_AAAA_AA49);
    tick();
    chk("arm_rise", 64'(d_arm), 64'h1);
    chk("arm_cnt4", 64'(d_cnt), 64'h4);
    chk("lfsr_step4", d_shr, 64'hAAAA_AAAA_AAAA_AA9C);
    tick();
    chk("arm_sat", 64'(d_cnt), 64'h4);
    chk("lfsr_step5", d_shr, 64'hAAAA_AAAA_AAAA_AA4E);

    // Hold after arming: registers freeze, arm is sticky
    mode = 2'b00;
    tick();
    tick();
    chk("sticky_freeze", d_shr, 64'hAAAA_AAAA_AAAA_AA4E);
    chk("sticky_arm", 64'(d_arm), 64'h1);
    chk("sticky_cnt", 64'(d_cnt), 64'h4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_reset("clr2");

    // Free rotate with every enable low
    mode = 2'b10;
    tick();
    tick();
    chk("free_step1", d_shr, 64'h5555_5555_5555_5555);
    tick();
    chk("free_step2", d_shr, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("free_one", o_shr, 64'h4040_4040_4040_4040);
    chk("free_cnt", 64'(d_cnt), 64'h0);

    // ch2: key strobe coinciding with a gated step
    mode = 2'b01;
    state[7:0] = 8'h01; rk_flat[263:256] = 8'h01; rk_valid = 8'h04;
    tick();
    rk_valid = 8'h00;
    chk("sim_en_load", 64'(d_en), 64'h04);
    chk("sim_no_step", d_shr, 64'hAAAA_AAAA_AAAA_AAAA);
    tick();
    tick();
    chk("sim_two_steps", d_shr, 64'hAAAA_AAAA_AAAA_AAAA);
    state[7:0] = 8'h03; rk_flat[263:256] = 8'h03; rk_valid = 8'h04;
    tick();
    rk_valid = 8'h00;
    chk("sim_old_en_step", d_shr, 64'hAAAA_AAAA_AA55_AAAA);
    chk("sim_en_cleared", 64'(d_en), 64'h00);
    tick();
    chk("sim_frozen", d_shr, 64'hAAAA_AAAA_AA55_AAAA);
    chk("sim_cnt", 64'(d_cnt), 64'h3);

    // Asynchronous reset mid-operation
    state[7:0] = 8'h01;
    for (int i = 0; i < 8; i++) rk_flat[i*128 +: 128] = 128'h01;
    rk_valid = 8'hFF;
    tick();
    rk_valid = 8'h00;
    tick();
    chk("pre_rst_shr", d_shr, 64'h5555_5555_55AA_5555);
    chk("pre_rst_arm", 64'(d_arm), 64'h1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("arst");
    #3;
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
